// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: two read ports, a byte-enabled write port
// qualified by wmfc, a reserve port and the per-register busy scoreboard.
interface register_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  localparam int DEPTH = 1 << ADDR_W;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic              wmfc;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W/8-1:0] wr_be;
  logic [DATA_W-1:0] wb_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [DEPTH-1:0]  busy;
  logic              hazard_a;
  logic              hazard_b;

  // Handshake: a write commits on a rising edge only when wr_en and wmfc are
  // both 1; reads are strobed by rd_en, reserves by rsv_en. No backpressure.
  modport master (
    output rd_en, rd_addr_a, rd_addr_b, wr_en, wmfc, wr_addr, wr_data, wr_be,
           rsv_en, rsv_addr,
    input  rd_data_a, rd_data_b, wb_data, busy, hazard_a, hazard_b
  );

  modport slave (
    input  rd_en, rd_addr_a, rd_addr_b, wr_en, wmfc, wr_addr, wr_data, wr_be,
           rsv_en, rsv_addr,
    output rd_data_a, rd_data_b, wb_data, busy, hazard_a, hazard_b
  );
endinterface

// File: rtl/register_file_mp.sv
// Two-read/one-write register file with byte enables, optional write-to-read
// forwarding, optional hard-wired zero register and a pending-write scoreboard.
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic clk,
  input logic reset,
  register_file_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] rd_a_q, rd_b_q, wb_q;
  logic [DEPTH-1:0]  busy_q, busy_next;

  logic              commit;
  logic              zero_wr;
  logic [DATA_W-1:0] wr_old, wr_merged;
  logic [DATA_W-1:0] rd_next_a, rd_next_b;

  assign commit  = bus.wr_en & bus.wmfc;
  assign zero_wr = (ZERO_REG != 0) && (bus.wr_addr == '0);
  assign wr_old  = regs[bus.wr_addr];

  always_comb begin
    wr_merged = wr_old;
    for (int i = 0; i < NB; i++) begin
      if (bus.wr_be[i]) wr_merged[8*i +: 8] = bus.wr_data[8*i +: 8];
    end
  end

  // Forwarding never targets a hard-wired zero register.
  always_comb begin
    rd_next_a = regs[bus.rd_addr_a];
    if ((ZERO_REG != 0) && (bus.rd_addr_a == '0))
      rd_next_a = '0;
    else if ((BYPASS != 0) && commit && !zero_wr && (bus.wr_addr == bus.rd_addr_a))
      rd_next_a = wr_merged;
  end

  always_comb begin
    rd_next_b = regs[bus.rd_addr_b];
    if ((ZERO_REG != 0) && (bus.rd_addr_b == '0))
      rd_next_b = '0;
    else if ((BYPASS != 0) && commit && !zero_wr && (bus.wr_addr == bus.rd_addr_b))
      rd_next_b = wr_merged;
  end

  // Clear on write first, then set on reserve so a same-address reserve wins.
  always_comb begin
    busy_next = busy_q;
    if (commit) busy_next[bus.wr_addr] = 1'b0;
    if (bus.rsv_en) busy_next[bus.rsv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      rd_a_q <= '0;
      rd_b_q <= '0;
      wb_q   <= '0;
      busy_q <= '0;
    end else begin
      if (commit && !zero_wr) regs[bus.wr_addr] <= wr_merged;
      if (bus.rd_en) begin
        rd_a_q <= rd_next_a;
        rd_b_q <= rd_next_b;
      end
      if (commit) wb_q <= zero_wr ? '0 : wr_merged;
      busy_q <= busy_next;
    end
  end

  assign bus.rd_data_a = rd_a_q;
  assign bus.rd_data_b = rd_b_q;
  assign bus.wb_data   = wb_q;
  assign bus.busy      = busy_q;
  // Hazards see the registered scoreboard; a same-cycle write clears it next cycle.
  assign bus.hazard_a  = bus.rd_en & busy_q[bus.rd_addr_a];
  assign bus.hazard_b  = bus.rd_en & busy_q[bus.rd_addr_b];
endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: two instances (bypass+zero-reg, and neither)
// share one stimulus stream and are checked against a behavioural model.
module tb_register_file_mp;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        rd_en, wr_en, wmfc, rsv_en;
  logic [3:0]  ra, rb, wa, rsv_addr;
  logic [31:0] wd;
  logic [3:0]  be;

  register_file_mp_if #(.DATA_W(32), .ADDR_W(4)) ifa ();
  register_file_mp_if #(.DATA_W(32), .ADDR_W(4)) ifb ();

  assign ifa.rd_en = rd_en;     assign ifb.rd_en = rd_en;
  assign ifa.rd_addr_a = ra;    assign ifb.rd_addr_a = ra;
  assign ifa.rd_addr_b = rb;    assign ifb.rd_addr_b = rb;
  assign ifa.wr_en = wr_en;     assign ifb.wr_en = wr_en;
  assign ifa.wmfc = wmfc;       assign ifb.wmfc = wmfc;
  assign ifa.wr_addr = wa;      assign ifb.wr_addr = wa;
  assign ifa.wr_data = wd;      assign ifb.wr_data = wd;
  assign ifa.wr_be = be;        assign ifb.wr_be = be;
  assign ifa.rsv_en = rsv_en;   assign ifb.rsv_en = rsv_en;
  assign ifa.rsv_addr = rsv_addr; assign ifb.rsv_addr = rsv_addr;

  register_file_mp #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) u_dut_byp (
    .clk(clk), .reset(reset), .bus(ifa));
  register_file_mp #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) u_dut_nob (
    .clk(clk), .reset(reset), .bus(ifb));

  logic [31:0] act_rda [2], act_rdb [2], act_wb [2];
  logic [15:0] act_busy [2];
  logic        act_hza [2], act_hzb [2];
  assign act_rda[0] = ifa.rd_data_a;  assign act_rda[1] = ifb.rd_data_a;
  assign act_rdb[0] = ifa.rd_data_b;  assign act_rdb[1] = ifb.rd_data_b;
  assign act_wb[0]  = ifa.wb_data;    assign act_wb[1]  = ifb.wb_data;
  assign act_busy[0] = ifa.busy;      assign act_busy[1] = ifb.busy;
  assign act_hza[0] = ifa.hazard_a;   assign act_hza[1] = ifb.hazard_a;
  assign act_hzb[0] = ifa.hazard_b;   assign act_hzb[1] = ifb.hazard_b;

  // Reference model: instance 0 has a zero register and forwarding, instance 1 neither.
  bit          zr [2];
  bit          byp [2];
  logic [31:0] m_r [2][16];
  logic [15:0] m_busy [2];
  logic [31:0] m_rda [2], m_rdb [2], m_wb [2];
  logic [31:0] exp_q [$];

  int cnt_cmp = 0;
  int cnt_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cnt_cmp++;
    if (got !== exp) begin
      cnt_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] en);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] read_val(input int k, input logic [3:0] addr,
                                           input bit commit, input logic [31:0] mg);
    if (zr[k] && addr == 0) return 32'h0;
    if (byp[k] && commit && addr == wa) return mg;
    return m_r[k][addr];
  endfunction

  task automatic push_exp();
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(m_rda[k]);
      exp_q.push_back(m_rdb[k]);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) m_r[k][i] = 32'h0;
      m_busy[k] = 16'h0;
      m_rda[k] = 32'h0;
      m_rdb[k] = 32'h0;
      m_wb[k] = 32'h0;
    end
    exp_q.delete();
    push_exp();
  endtask

  task automatic model_edge();
    bit commit, zw;
    logic [31:0] mg;
    commit = wr_en && wmfc;
    for (int k = 0; k < 2; k++) begin
      zw = zr[k] && (wa == 0);
      mg = merge(m_r[k][wa], wd, be);
      if (rd_en) begin
        m_rda[k] = read_val(k, ra, commit && !zw, mg);
        m_rdb[k] = read_val(k, rb, commit && !zw, mg);
      end
      if (commit) begin
        m_wb[k] = zw ? 32'h0 : mg;
        if (!zw) m_r[k][wa] = mg;
        m_busy[k][wa] = 1'b0;
      end
      if (rsv_en && !(zr[k] && rsv_addr == 0)) m_busy[k][rsv_addr] = 1'b1;
    end
    push_exp();
  endtask

  task automatic check_state();
    logic [31:0] e;
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      check($sformatf("rd_data_a[%0d]", k), act_rda[k], e);
      e = exp_q.pop_front();
      check($sformatf("rd_data_b[%0d]", k), act_rdb[k], e);
      check($sformatf("wb_data[%0d]", k), act_wb[k], m_wb[k]);
      check($sformatf("busy[%0d]", k), {16'h0, act_busy[k]}, {16'h0, m_busy[k]});
    end
  endtask

  // Inputs are set just after a falling edge; hazards are sampled pre-edge,
  // registered outputs at the following falling edge.
  task automatic cycle();
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("hazard_a[%0d]", k), {31'h0, act_hza[k]}, {31'h0, rd_en && m_busy[k][ra]});
      check($sformatf("hazard_b[%0d]", k), {31'h0, act_hzb[k]}, {31'h0, rd_en && m_busy[k][rb]});
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_state();
  endtask

  task automatic idle();
    rd_en = 0; wr_en = 0; wmfc = 0; rsv_en = 0;
    ra = 0; rb = 0; wa = 0; rsv_addr = 0; wd = 0; be = 0;
  endtask

  task automatic drive_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] en,
                          input logic mfc);
    wr_en = 1; wmfc = mfc; wa = a; wd = d; be = en;
  endtask

  task automatic drive_rd(input logic [3:0] a, input logic [3:0] b);
    rd_en = 1; ra = a; rb = b;
  endtask

  initial begin
    zr[0] = 1; byp[0] = 1;
    zr[1] = 0; byp[1] = 0;
    idle();
    reset = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_state();
    reset = 1;

    // Full write, then read back.
    idle(); drive_wr(5, 32'hDEADBEEF, 4'hF, 1); cycle();
    check("wb_full", act_wb[0], 32'hDEADBEEF);
    idle(); drive_rd(5, 5); cycle();
    check("rd_full_a0", act_rda[0], 32'hDEADBEEF);
    check("rd_full_b1", act_rdb[1], 32'hDEADBEEF);

    // Partial write, then an unqualified write that must not commit.
    idle(); drive_wr(5, 32'h11223344, 4'h3, 1); cycle();
    idle(); drive_wr(5, 32'h0, 4'hF, 0); cycle();
    check("wb_no_mfc", act_wb[0], 32'hDEAD3344);
    idle(); drive_rd(5, 0); cycle();
    check("rd_partial", act_rda[0], 32'hDEAD3344);
    check("rd_zero_b", act_rdb[0], 32'h0);

    // Same-edge write and read of R7: forwarded vs. old value.
    idle(); drive_wr(7, 32'h12345678, 4'hF, 1); cycle();
    idle(); drive_wr(7, 32'hA5A5A5A5, 4'hF, 1); drive_rd(7, 7); cycle();
    check("bypass_on", act_rda[0], 32'hA5A5A5A5);
    check("bypass_off", act_rda[1], 32'h12345678);

    // Writes and reserves to register 0.
    idle(); drive_wr(0, 32'hFFFFFFFF, 4'hF, 1); rsv_en = 1; rsv_addr = 0; cycle();
    check("zero_wb", act_wb[0], 32'h0);
    check("zero_busy0", {31'h0, act_busy[0][0]}, 32'h0);
    idle(); drive_rd(0, 0); cycle();
    check("zero_rd", act_rda[0], 32'h0);
    check("nozero_rd", act_rda[1], 32'hFFFFFFFF);

    // Scoreboard: reserve, hazard, reserve+write priority, write-only clear.
    idle(); rsv_en = 1; rsv_addr = 3; cycle();
    idle(); drive_rd(3, 3);
    #1 check("hazard_set", {31'h0, act_hza[0]}, 32'h1);
    cycle();
    idle(); drive_wr(3, 32'h0BADF00D, 4'hF, 1); rsv_en = 1; rsv_addr = 3; cycle();
    check("rsv_priority", {31'h0, act_busy[0][3]}, 32'h1);
    idle(); drive_wr(3, 32'hCAFE0003, 4'hF, 1); drive_rd(3, 3);
    #1 check("hazard_same_cycle", {31'h0, act_hza[0]}, 32'h1);
    cycle();
    check("busy_cleared", {31'h0, act_busy[0][3]}, 32'h0);
    idle(); drive_rd(3, 5);
    #1 check("hazard_gone", {31'h0, act_hza[0]}, 32'h0);
    cycle();

    // Asynchronous reset between edges with activity pending.
    idle(); drive_wr(5, 32'h55555555, 4'hF, 1); rsv_en = 1; rsv_addr = 9; drive_rd(5, 7);
    #2 reset = 0;
    model_reset();
    #1 check_state();
    @(posedge clk);
    @(negedge clk);
    idle(); reset = 1;
    push_exp(); check_state();
    drive_rd(5, 7); cycle();
    check("post_reset_r5", act_rda[0], 32'h0);

    // Random traffic concentrated on a few addresses to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      idle();
      rd_en = ($urandom_range(0, 9) < 7);
      ra = 4'($urandom_range(0, 7));
      rb = 4'($urandom_range(0, 7));
      wr_en = ($urandom_range(0, 9) < 6);
      wmfc = ($urandom_range(0, 9) < 7);
      wa = 4'($urandom_range(0, 7));
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      rsv_en = ($urandom_range(0, 9) < 3);
      rsv_addr = 4'($urandom_range(0, 7));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_bad);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 4, address width; depth SHALL be 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1; 1 means register 0 is hard-wired to zero.
REQ-004 Parameter BYPASS, default 1; 1 means a same-cycle write forwards to the read ports.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 rd_en  input  1  read strobe for both read ports.
REQ-008 rd_addr_a, rd_addr_b  input  ADDR_W  read addresses.
REQ-009 rd_data_a, rd_data_b  output  DATA_W  registered read data.
REQ-010 wr_en  input  1  write request.
REQ-011 wmfc  input  1  memory-function-complete qualifier; a write SHALL commit only when wr_en=1 and wmfc=1.
REQ-012 wr_addr  input  ADDR_W  write address.
REQ-013 wr_data  input  DATA_W  write data.
REQ-014 wr_be  input  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i].
REQ-015 wb_data  output  DATA_W  registered copy of the destination register after a committed write.
REQ-016 rsv_en, rsv_addr  input  1, ADDR_W  reserve a destination (pending write).
REQ-017 busy  output  2**ADDR_W  scoreboard, one pending bit per register.
REQ-018 hazard_a, hazard_b  output  1  combinational; rd_en=1 and the addressed register is busy.

Function
REQ-019 Read latency SHALL be one cycle: rd_data_x at edge N+1 reflects the register addressed at edge N with rd_en=1; with rd_en=0, rd_data_x SHALL hold.
REQ-020 Committed write SHALL update only the enabled bytes of R[wr_addr]; other bytes keep their values.
REQ-021 wr_en=1 with wmfc=0 SHALL change no register, no busy bit and no wb_data.
REQ-022 When BYPASS=1 and a committed write targets a read address on the same edge, the read SHALL return the merged post-write value (per byte enables); when BYPASS=0, it SHALL return the pre-write value.
REQ-023 When ZERO_REG=1, writes to address 0 SHALL be discarded, reads of address 0 SHALL return 0, bypass SHALL never apply to address 0, and busy[0] SHALL stay 0.
REQ-024 On each committed write, wb_data SHALL load the post-write value of R[wr_addr] (0 for address 0 when ZERO_REG=1); otherwise it holds.
REQ-025 rsv_en=1 SHALL set busy[rsv_addr] on the clock edge.
REQ-026 A committed write SHALL clear busy[wr_addr].
REQ-027 When a reserve and a committed write target the same address on the same edge, the reserve SHALL take priority (busy stays 1) and the data write SHALL still commit.
REQ-028 Reserves and writes to different addresses on the same edge SHALL both take effect independently.
REQ-029 hazard_x SHALL use the current busy value and SHALL not be cleared by a write in the same cycle; the write-clear is visible from the next cycle.
REQ-030 Both read ports MAY address the same register and SHALL return identical data.

Reset
REQ-031 While reset=0, all registers, rd_data_a, rd_data_b, wb_data and busy SHALL be 0, regardless of clk.
REQ-032 Reset asserted mid-operation SHALL abort any write or reserve in progress; no partial update SHALL survive.
REQ-033 The first edge after reset deasserts SHALL perform normal operation.

Verification
REQ-034 Reset, then write R5=0xDEADBEEF with be=0xF and wmfc=1, read a=5 -> rd_data_a=0xDEADBEEF one cycle later; wb_data=0xDEADBEEF.
REQ-035 R5=0xDEADBEEF, write 0x11223344 with be=0x3 -> R5=0xDEAD3344; wr_en=1 with wmfc=0 and data 0 -> R5 unchanged.
REQ-036 BYPASS=1: write R7=0xA5A5A5A5 and read a=7 on the same edge -> rd_data_a=0xA5A5A5A5; BYPASS=0 -> rd_data_a=the old R7 value.
REQ-037 ZERO_REG=1: write R0=0xFFFFFFFF and rsv R0 -> read R0=0, busy[0]=0, wb_data=0.
REQ-038 rsv R3, then rd_en with a=3 -> hazard_a=1; reserve and write R3 on the same edge -> busy[3] stays 1; a later write alone -> busy[3]=0 and hazard_a=0 the next cycle.
REQ-039 Assert reset=0 between edges while busy and registers are nonzero -> all outputs 0 immediately; after release, a read of R5 returns 0.
